l2b_sio_resp_tx: RTL and testbench

L2-bank-side transmitter for the outbound L2-to-SIO response interface: it accepts one response descriptor at a time from the bank's IO response logic and drives `l2b_sio_ctag_vld`, `l2b_sio_data`, `l2b_sio_parity` and `l2b_sio_ue_err` toward SIO. A response is either a header-only cycle (write-8 or write-invalidate ack) or a header followed by 16 data beats (a 64-byte read). One instance sits in each of the eight L2 banks, in the `iol2clk` domain. Transmission is gated by a credit count that tracks SIO's per-bank response buffer.

---
 rtl/l2b_sio_pkg.sv | 38 +++
 rtl/l2b_sio_credit_cnt.sv | 44 ++++
 rtl/l2b_sio_resp_tx.sv | 133 +++++++++++++
 tb/tb_l2b_sio_resp_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l2b_sio_pkg.sv
// Shared definitions for the L2-bank to SIO response transmitter:
// header layout, beat count, FSM encodings, descriptor record and parity helper.
package l2b_sio_pkg;

    localparam int OPES_LSB      = 20;
    localparam int CBA_LSB       = 16;
    localparam int TAG_LSB       = 0;
    localparam int L2B_SIO_BEATS = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    typedef struct packed {
        logic [3:0]   opes;
        logic [3:0]   cba;
        logic [15:0]  tag;
        logic         has_data;
        logic         ue;
        logic [511:0] data;
    } resp_desc_t;

    function automatic logic [1:0] par2(input logic [31:0] d);
        return {^d[31:16], ^d[15:0]};
    endfunction

    function automatic logic [31:0] hdr_word(input logic [3:0] opes,
                                             input logic [3:0] cba,
                                             input logic [15:0] tag);
        logic [31:0] w;
        w = '0;
        w[OPES_LSB +: 4] = opes;
        w[CBA_LSB  +: 4] = cba;
        w[TAG_LSB  +: 16] = tag;
        return w;
    endfunction

endpackage

// File: rtl/l2b_sio_credit_cnt.sv
// Tracks free entries in SIO's per-bank response buffer; exposes the next
// count so the transmitter can register its ready flag without a bubble.
module l2b_sio_credit_cnt #(
    parameter int CREDITS = 4,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic             iol2clk,
    input  logic             rst_l,
    input  logic             consume,
    input  logic             ret,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             credit_ovf
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (consume && !ret) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (ret && !consume) begin
            // A return with the buffer already fully credited is a protocol error upstream.
            if (cnt_q == CNT_W'(CREDITS)) ovf_d = 1'b1;
            else                          cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q <= CNT_W'(CREDITS);
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_nxt    = cnt_d;
    assign credit_ovf = ovf_q;

endmodule

// File: rtl/l2b_sio_resp_tx.sv
// Serialises one response descriptor into a header cycle plus optional 16
// data beats toward SIO, gated by the per-bank credit count. All outputs registered.
module l2b_sio_resp_tx
    import l2b_sio_pkg::*;
#(
    parameter int CREDITS = 4
) (
    input  logic         iol2clk,
    input  logic         rst_l,
    input  logic         req_vld,
    output logic         req_rdy,
    input  logic [3:0]   req_opes,
    input  logic [3:0]   req_cba,
    input  logic [15:0]  req_tag,
    input  logic         req_has_data,
    input  logic         req_ue,
    input  logic [511:0] req_data,
    input  logic         sio_l2b_credit_ret,
    output logic         l2b_sio_ctag_vld,
    output logic [31:0]  l2b_sio_data,
    output logic [1:0]   l2b_sio_parity,
    output logic         l2b_sio_ue_err,
    output logic         credit_ovf
);

    localparam int CNT_W = $clog2(CREDITS + 1);
    localparam logic [3:0] LAST_BEAT = 4'(L2B_SIO_BEATS - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       beat_q, beat_d;
    resp_desc_t       desc_q, desc_d;
    logic             rdy_q, rdy_d;
    logic             ctag_q, ctag_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       par_q, par_d;
    logic             ue_q, ue_d;
    logic             accept;
    logic             last_d;
    logic [3:0]       word_idx;
    logic [CNT_W-1:0] cnt_nxt;

    assign accept = req_vld && rdy_q;

    l2b_sio_credit_cnt #(
        .CREDITS (CREDITS),
        .CNT_W   (CNT_W)
    ) u_credit (
        .iol2clk    (iol2clk),
        .rst_l      (rst_l),
        .consume    (accept),
        .ret        (sio_l2b_credit_ret),
        .cnt_nxt    (cnt_nxt),
        .credit_ovf (credit_ovf)
    );

    // NOTE: every variable is given a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        desc_d  = desc_q;
        if (accept) begin
            desc_d = '{opes: req_opes, cba: req_cba, tag: req_tag,
                       has_data: req_has_data, ue: req_ue, data: req_data};
        end
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_HDR;
            ST_HDR: begin
                if (desc_q.has_data) begin
                    state_d = ST_DATA;
                    beat_d  = 4'd0;
                end else begin
                    state_d = accept ? ST_HDR : ST_IDLE;
                end
            end
            ST_DATA: begin
                beat_d = beat_q + 4'd1;
                if (beat_q == LAST_BEAT) state_d = accept ? ST_HDR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are computed from next-state values so they line up with the state flops.
        ctag_d   = 1'b0;
        data_d   = '0;
        ue_d     = 1'b0;
        word_idx = LAST_BEAT - beat_d;
        if (state_d == ST_HDR) begin
            ctag_d = 1'b1;
            data_d = hdr_word(desc_d.opes, desc_d.cba, desc_d.tag);
            ue_d   = desc_d.ue;
        end else if (state_d == ST_DATA) begin
            data_d = desc_d.data[{word_idx, 5'd0} +: 32];
            ue_d   = desc_d.ue;
        end
        par_d = par2(data_d);

        last_d = (state_d == ST_HDR && !desc_d.has_data) ||
                 (state_d == ST_DATA && beat_d == LAST_BEAT);
        rdy_d  = (state_d == ST_IDLE || last_d) && (cnt_nxt != '0);
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
            beat_q  <= 4'd0;
            rdy_q   <= 1'b0;
            ctag_q  <= 1'b0;
            data_q  <= '0;
            par_q   <= 2'b00;
            ue_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rdy_q   <= rdy_d;
            ctag_q  <= ctag_d;
            data_q  <= data_d;
            par_q   <= par_d;
            ue_q    <= ue_d;
        end
    end

    // NOTE: the wide descriptor holding register is left unreset; it is only read while the FSM is out of IDLE.
    always_ff @(posedge iol2clk) begin
        desc_q <= desc_d;
    end

    assign req_rdy          = rdy_q;
    assign l2b_sio_ctag_vld = ctag_q;
    assign l2b_sio_data     = data_q;
    assign l2b_sio_parity   = par_q;
    assign l2b_sio_ue_err   = ue_q;

endmodule

// File: tb/tb_l2b_sio_resp_tx.sv
// Directed, table-driven bench for l2b_sio_resp_tx: header-only vectors,
// read serialisation, credit exhaustion/overflow, back-to-back and mid-read reset.
module tb_l2b_sio_resp_tx;

    logic         iol2clk = 1'b0;
    logic         rst_l;
    logic         req_vld;
    logic         req_rdy;
    logic [3:0]   req_opes;
    logic [3:0]   req_cba;
    logic [15:0]  req_tag;
    logic         req_has_data;
    logic         req_ue;
    logic [511:0] req_data;
    logic         sio_l2b_credit_ret;
    logic         l2b_sio_ctag_vld;
    logic [31:0]  l2b_sio_data;
    logic [1:0]   l2b_sio_parity;
    logic         l2b_sio_ue_err;
    logic         credit_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0]  opes;
        logic [3:0]  cba;
        logic [15:0] tag;
        logic        ue;
        logic [31:0] exp_data;
        logic [1:0]  exp_par;
    } hdr_vec_t;

    hdr_vec_t     vec[6];
    logic [511:0] rd_data;

    l2b_sio_resp_tx #(.CREDITS(4)) dut (
        .iol2clk            (iol2clk),
        .rst_l              (rst_l),
        .req_vld            (req_vld),
        .req_rdy            (req_rdy),
        .req_opes           (req_opes),
        .req_cba            (req_cba),
        .req_tag            (req_tag),
        .req_has_data       (req_has_data),
        .req_ue             (req_ue),
        .req_data           (req_data),
        .sio_l2b_credit_ret (sio_l2b_credit_ret),
        .l2b_sio_ctag_vld   (l2b_sio_ctag_vld),
        .l2b_sio_data       (l2b_sio_data),
        .l2b_sio_parity     (l2b_sio_parity),
        .l2b_sio_ue_err     (l2b_sio_ue_err),
        .credit_ovf         (credit_ovf)
    );

    always #5 iol2clk = ~iol2clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge iol2clk);
        #1;
    endtask

    function automatic logic [1:0] exp_par(input logic [31:0] w);
        return {^w[31:16], ^w[15:0]};
    endfunction

    task automatic check_hdr(input string tag, input logic [31:0] d, input logic [1:0] p, input logic ue);
        check({tag, " ctag"},   32'(l2b_sio_ctag_vld), 32'd1);
        check({tag, " data"},   l2b_sio_data, d);
        check({tag, " parity"}, 32'(l2b_sio_parity), 32'(p));
        check({tag, " ue"},     32'(l2b_sio_ue_err), 32'(ue));
    endtask

    task automatic check_idle(input string tag);
        check({tag, " idle ctag"},   32'(l2b_sio_ctag_vld), 32'd0);
        check({tag, " idle data"},   l2b_sio_data, 32'd0);
        check({tag, " idle parity"}, 32'(l2b_sio_parity), 32'd0);
        check({tag, " idle ue"},     32'(l2b_sio_ue_err), 32'd0);
    endtask

    task automatic set_hdr_req(input logic [3:0] o, input logic [3:0] c, input logic [15:0] t, input logic ue);
        req_opes = o; req_cba = c; req_tag = t; req_ue = ue;
        req_has_data = 1'b0; req_data = '0;
    endtask

    task automatic set_read_req(input logic ue);
        req_opes = 4'h1; req_cba = 4'h5; req_tag = 16'h1234; req_ue = ue;
        req_has_data = 1'b1; req_data = rd_data;
    endtask

    initial begin
        vec[0] = '{4'h9, 4'h2, 16'hBEEF, 1'b0, 32'h0092_BEEF, 2'b11};
        vec[1] = '{4'h0, 4'h0, 16'h0000, 1'b1, 32'h0000_0000, 2'b00};
        vec[2] = '{4'hF, 4'hF, 16'hFFFF, 1'b0, 32'h00FF_FFFF, 2'b00};
        vec[3] = '{4'h1, 4'h0, 16'h0001, 1'b1, 32'h0010_0001, 2'b11};
        vec[4] = '{4'h3, 4'h0, 16'h0007, 1'b0, 32'h0030_0007, 2'b01};
        vec[5] = '{4'h1, 4'h0, 16'h0003, 1'b1, 32'h0010_0003, 2'b10};
        for (int k = 0; k < 16; k++) rd_data[511 - 32*k -: 32] = 32'h1000_0000 + 32'(k);

        rst_l = 1'b0;
        req_vld = 1'b0;
        sio_l2b_credit_ret = 1'b0;
        set_hdr_req(4'h0, 4'h0, 16'h0, 1'b0);
        #12;
        check_idle("reset");
        check("reset rdy", 32'(req_rdy), 32'd0);
        check("reset ovf", 32'(credit_ovf), 32'd0);
        rst_l = 1'b1;
        step();
        check("post-reset rdy", 32'(req_rdy), 32'd1);

        // Header-only table, one credit returned after each response.
        for (int i = 0; i < 6; i++) begin
            check($sformatf("vec%0d rdy", i), 32'(req_rdy), 32'd1);
            set_hdr_req(vec[i].opes, vec[i].cba, vec[i].tag, vec[i].ue);
            req_vld = 1'b1;
            step();
            check_hdr($sformatf("vec%0d", i), vec[i].exp_data, vec[i].exp_par, vec[i].ue);
            req_vld = 1'b0;
            sio_l2b_credit_ret = 1'b1;
            step();
            sio_l2b_credit_ret = 1'b0;
            check_idle($sformatf("vec%0d", i));
        end

        // Return at full count: single overflow pulse.
        check("pre-ovf", 32'(credit_ovf), 32'd0);
        sio_l2b_credit_ret = 1'b1;
        step();
        sio_l2b_credit_ret = 1'b0;
        check("ovf pulse", 32'(credit_ovf), 32'd1);
        step();
        check("ovf cleared", 32'(credit_ovf), 32'd0);

        // Exhaustion: four accepts from a full count, then stall.
        set_hdr_req(4'h9, 4'h2, 16'hBEEF, 1'b0);
        req_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("exh hdr%0d ctag", i), 32'(l2b_sio_ctag_vld), 32'd1);
        end
        check("exh rdy low", 32'(req_rdy), 32'd0);
        step();
        check("exh stalled ctag", 32'(l2b_sio_ctag_vld), 32'd0);
        sio_l2b_credit_ret = 1'b1;
        step();
        sio_l2b_credit_ret = 1'b0;
        check("ret not same-cycle ctag", 32'(l2b_sio_ctag_vld), 32'd0);
        check("ret raises rdy", 32'(req_rdy), 32'd1);
        step();
        check_hdr("fifth", 32'h0092_BEEF, 2'b11, 1'b0);
        req_vld = 1'b0;
        step();
        check_idle("fifth");

        // Simultaneous accept and return at count 2.
        sio_l2b_credit_ret = 1'b1;
        step();
        step();
        req_vld = 1'b1;
        step();
        sio_l2b_credit_ret = 1'b0;
        check("simul hdr", 32'(l2b_sio_ctag_vld), 32'd1);
        check("simul rdy", 32'(req_rdy), 32'd1);
        step();
        check("simul+1 rdy", 32'(req_rdy), 32'd1);
        step();
        check("simul+2 rdy", 32'(req_rdy), 32'd0);
        check("simul+2 ctag", 32'(l2b_sio_ctag_vld), 32'd1);
        req_vld = 1'b0;
        step();
        check_idle("simul");

        // Read followed back-to-back by a header-only request.
        sio_l2b_credit_ret = 1'b1;
        step();
        step();
        sio_l2b_credit_ret = 1'b0;
        set_read_req(1'b1);
        req_vld = 1'b1;
        step();
        check_hdr("read", 32'h0015_1234, 2'b11, 1'b1);
        check("read hdr rdy", 32'(req_rdy), 32'd0);
        set_hdr_req(4'h9, 4'h2, 16'hBEEF, 1'b0);
        for (int k = 0; k < 16; k++) begin
            logic [31:0] w;
            w = 32'h1000_0000 + 32'(k);
            step();
            check($sformatf("beat%0d data", k), l2b_sio_data, w);
            check($sformatf("beat%0d par", k), 32'(l2b_sio_parity), 32'(exp_par(w)));
            check($sformatf("beat%0d ctag", k), 32'(l2b_sio_ctag_vld), 32'd0);
            check($sformatf("beat%0d ue", k), 32'(l2b_sio_ue_err), 32'd1);
        end
        check("beat15 rdy", 32'(req_rdy), 32'd1);
        step();
        check_hdr("b2b", 32'h0092_BEEF, 2'b11, 1'b0);
        req_vld = 1'b0;
        step();
        check_idle("b2b");

        // Reset while beat 7 of a read is on the wire.
        sio_l2b_credit_ret = 1'b1;
        step();
        sio_l2b_credit_ret = 1'b0;
        set_read_req(1'b0);
        req_vld = 1'b1;
        step();
        req_vld = 1'b0;
        check("rst-read hdr", 32'(l2b_sio_ctag_vld), 32'd1);
        for (int k = 0; k < 8; k++) step();
        check("rst-read beat7", l2b_sio_data, 32'h1000_0007);
        #2;
        rst_l = 1'b0;
        #1;
        check_idle("midrst");
        check("midrst rdy", 32'(req_rdy), 32'd0);
        #1;
        rst_l = 1'b1;
        step();
        check("post-midrst rdy", 32'(req_rdy), 32'd1);
        set_hdr_req(4'h3, 4'h0, 16'h0007, 1'b1);
        req_vld = 1'b1;
        // Four back-to-back accepts prove credits were restored to full.
        for (int i = 0; i < 4; i++) begin
            step();
            check_hdr($sformatf("post-rst%0d", i), 32'h0030_0007, 2'b01, 1'b1);
        end
        check("post-rst rdy low", 32'(req_rdy), 32'd0);
        req_vld = 1'b0;
        step();
        check_idle("post-rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
